// File: rtl/stream_prefetch_buffer.sv
// stream_prefetch_buffer
// Small fully-associative prefetch buffer that sits beside a cache. When a
// cache demand miss arrives, the buffer is looked up for that line. It then
// prefetches the next DEGREE consecutive lines, skipping lines it already
// holds. Fills are placed in round-robin order.
// Optional feature macro: PF_INVALIDATE_ON_HIT_EN. When defined, a lookup hit
// drops the entry because the line has moved into the cache.
module stream_prefetch_buffer #(
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int BUF_DEPTH       = 8,
  parameter int DEGREE          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cache_miss,
  input  logic [31:0]                  address,
  output logic                         pf_hit,
  output logic                         pf_miss,
  output logic [BLOCK_SIZE_BYTE*8-1:0] pf_data,
  output logic                         busy,
  output logic                         mem_req_valid,
  output logic [31:0]                  mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         fill_valid,
  input  logic [BLOCK_SIZE_BYTE*8-1:0] fill_data
);

  localparam int OFFS  = $clog2(BLOCK_SIZE_BYTE);
  localparam int TAGW  = 32 - OFFS;
  localparam int PTRW  = $clog2(BUF_DEPTH);
  localparam int CNTW  = $clog2(BUF_DEPTH) + 1;
  localparam int LINEW = BLOCK_SIZE_BYTE * 8;

  localparam logic [TAGW-1:0] ONE_LINE   = TAGW'(1);
  localparam logic [CNTW-1:0] LAST_COUNT = CNTW'(DEGREE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    WAIT_FILL
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Buffer storage. Only the valid bits need a reset value.
  logic [BUF_DEPTH-1:0] r_valid;
  logic [TAGW-1:0]      r_tag  [BUF_DEPTH];
  logic [LINEW-1:0]     r_data [BUF_DEPTH];

  logic [PTRW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_count;
  logic [TAGW-1:0]  r_line;
  logic [TAGW-1:0]  r_cand;
  logic [LINEW-1:0] r_pfData;

  logic             w_lookupHit;
  logic [PTRW-1:0]  w_lookupIdx;
  logic             w_candHit;
  logic             w_advance;
  logic             w_fillWrite;
  logic             w_unusedAddrBits;

  // The byte offset within a line never affects buffer behaviour.
  assign w_unusedAddrBits = ^address[OFFS-1:0];

  // Demand lookup. The scan runs downward so that the lowest matching index wins.
  always_comb begin
    w_lookupHit = 1'b0;
    w_lookupIdx = '0;
    for (int i = BUF_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_line)) begin
        w_lookupHit = 1'b1;
        w_lookupIdx = PTRW'(i);
      end
    end
  end

  // Detect whether the current prefetch candidate is already held, so it can be skipped.
  always_comb begin
    w_candHit = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (r_valid[i] && (r_tag[i] == r_cand)) begin
        w_candHit = 1'b1;
      end
    end
  end

  // Next-state logic. A skip or a fill both count as one completed prefetch step.
  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    w_fillWrite = 1'b0;
    case (r_state)
      IDLE: begin
        if (cache_miss) begin
          w_nextState = LOOKUP;
        end
      end
      LOOKUP: begin
        w_nextState = ISSUE;
      end
      ISSUE: begin
        if (w_candHit) begin
          w_advance = 1'b1;
        end else if (mem_req_ready) begin
          w_nextState = WAIT_FILL;
        end
      end
      WAIT_FILL: begin
        if (fill_valid) begin
          w_fillWrite = 1'b1;
          w_advance   = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_advance) begin
      w_nextState = (r_count == LAST_COUNT) ? IDLE : ISSUE;
    end
  end

  // Control state: FSM, latched miss line, prefetch candidate and count,
  // round-robin pointer, valid bits and the held hit data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_valid  <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_line   <= '0;
      r_cand   <= '0;
      r_pfData <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (cache_miss) begin
            r_line <= address[31:OFFS];
          end
        end
        LOOKUP: begin
          r_cand  <= r_line + ONE_LINE;
          r_count <= '0;
          if (w_lookupHit) begin
            r_pfData <= r_data[w_lookupIdx];
`ifdef PF_INVALIDATE_ON_HIT_EN
            r_valid[w_lookupIdx] <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
      if (w_advance) begin
        r_count <= r_count + CNTW'(1);
        r_cand  <= r_cand + ONE_LINE;
      end
      if (w_fillWrite) begin
        r_valid[r_ptr] <= 1'b1;
        r_ptr          <= r_ptr + PTRW'(1);
      end
    end
  end

  // Fill write into the entry at the round-robin pointer, overwriting whatever was there.
  always_ff @(posedge clk) begin
    if (!rst && w_fillWrite) begin
      r_tag[r_ptr]  <= r_cand;
      r_data[r_ptr] <= fill_data;
    end
  end

  assign busy          = (r_state != IDLE);
  assign pf_hit        = (r_state == LOOKUP) && w_lookupHit;
  assign pf_miss       = (r_state == LOOKUP) && !w_lookupHit;
  assign pf_data       = pf_hit ? r_data[w_lookupIdx] : r_pfData;
  assign mem_req_valid = (r_state == ISSUE) && !w_candHit;
  assign mem_req_addr  = mem_req_valid ? {r_cand, {OFFS{1'b0}}} : 32'h0;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Testbench for stream_prefetch_buffer (default parameters).
// Directed scenarios and random demand misses are checked against a
// transaction-level model of the buffer contents.
module tb_stream_prefetch_buffer;

  localparam int DEPTH = 8;
  localparam int DEG   = 2;
  localparam int LINEW = 128;

  logic             clk = 1'b0;
  logic             rst;
  logic             cache_miss;
  logic [31:0]      address;
  logic             pf_hit;
  logic             pf_miss;
  logic [LINEW-1:0] pf_data;
  logic             busy;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic             mem_req_ready;
  logic             fill_valid;
  logic [LINEW-1:0] fill_data;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: the buffer contents seen as plain arrays
  logic             mValid [DEPTH];
  logic [27:0]      mLine  [DEPTH];
  logic [LINEW-1:0] mData  [DEPTH];
  int               mPtr;
  logic [LINEW-1:0] mLastData;

  stream_prefetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .cache_miss    (cache_miss),
    .address       (address),
    .pf_hit        (pf_hit),
    .pf_miss       (pf_miss),
    .pf_data       (pf_data),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .fill_valid    (fill_valid),
    .fill_data     (fill_data)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [LINEW-1:0] observed,
                             input logic [LINEW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [LINEW-1:0] randLine();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int modelFind(input logic [27:0] line);
    for (int i = 0; i < DEPTH; i++) begin
      if (mValid[i] && mLine[i] == line) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
    mPtr      = 0;
    mLastData = '0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst           = 1'b1;
    cache_miss    = 1'b0;
    mem_req_ready = 1'b0;
    fill_valid    = 1'b0;
    stepCycle();
    checkOutput("rstPfHit", pf_hit, 0);
    checkOutput("rstPfMiss", pf_miss, 0);
    checkOutput("rstReqValid", mem_req_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstPfData", pf_data, 0);
    checkOutput("rstReqAddr", mem_req_addr, 0);
    rst = 1'b0;
    modelReset();
  endtask

  // One complete demand miss: lookup, then DEGREE prefetch steps. Ready and fill
  // timing is random, and stray misses and fills are sprinkled in where they must be ignored.
  task automatic applyStimulus(input logic [31:0] addr);
    logic [27:0]      line;
    logic [27:0]      cand;
    logic [31:0]      reqAddr;
    logic [LINEW-1:0] fd;
    int               idx;
    int               waitCycles;
    int               gapCycles;
    line       = addr[31:4];
    cache_miss = 1'b1;
    address    = addr;
    stepCycle();
    cache_miss = 1'b0;
    address    = $urandom();
    idx = modelFind(line);
    checkOutput("pfHit", pf_hit, idx >= 0);
    checkOutput("pfMiss", pf_miss, idx < 0);
    if (idx >= 0) begin
      mLastData = mData[idx];
`ifdef PF_INVALIDATE_ON_HIT_EN
      mValid[idx] = 1'b0;
`endif
    end
    checkOutput("pfData", pf_data, mLastData);
    checkOutput("busyLookup", busy, 1);
    stepCycle();
    for (int k = 0; k < DEG; k++) begin
      cand = line + 28'(k + 1);
      if (modelFind(cand) >= 0) begin
        checkOutput("skipNoReq", mem_req_valid, 0);
        stepCycle();
      end else begin
        reqAddr = {cand, 4'h0};
        checkOutput("reqValid", mem_req_valid, 1);
        checkOutput("reqAddr", mem_req_addr, reqAddr);
        waitCycles = int'($urandom_range(0, 3));
        for (int w = 0; w < waitCycles; w++) begin
          fill_valid = 1'($urandom_range(0, 1));
          cache_miss = 1'($urandom_range(0, 1));
          fill_data  = randLine();
          stepCycle();
          fill_valid = 1'b0;
          cache_miss = 1'b0;
          checkOutput("reqHeldValid", mem_req_valid, 1);
          checkOutput("reqHeldAddr", mem_req_addr, reqAddr);
        end
        mem_req_ready = 1'b1;
        stepCycle();
        mem_req_ready = 1'b0;
        checkOutput("reqDrop", mem_req_valid, 0);
        gapCycles = int'($urandom_range(0, 3));
        for (int g = 0; g < gapCycles; g++) begin
          cache_miss = 1'($urandom_range(0, 1));
          stepCycle();
          cache_miss = 1'b0;
        end
        fd         = randLine();
        fill_valid = 1'b1;
        fill_data  = fd;
        stepCycle();
        fill_valid   = 1'b0;
        mValid[mPtr] = 1'b1;
        mLine[mPtr]  = cand;
        mData[mPtr]  = fd;
        mPtr         = (mPtr + 1) % DEPTH;
      end
    end
    checkOutput("busyDone", busy, 0);
  endtask

  initial begin
    int idx;
    rst           = 1'b1;
    cache_miss    = 1'b0;
    address       = '0;
    mem_req_ready = 1'b0;
    fill_valid    = 1'b0;
    fill_data     = '0;
    modelReset();
    doReset();

    $display("[TB] basic miss and prefetch at 0x1000");
    applyStimulus(32'h0000_1000);

    $display("[TB] hit on a prefetched line at 0x1014");
    applyStimulus(32'h0000_1014);
    applyStimulus(32'h0000_1014);

    $display("[TB] wrap at top of address space");
    applyStimulus(32'hFFFF_FFF0);

    $display("[TB] round-robin eviction");
    doReset();
    for (int n = 0; n < 5; n++) applyStimulus(32'h0000_2000 + 32'(n) * 32'h2000);
    applyStimulus(32'h0000_2010);

    $display("[TB] random demand misses");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(32'h0000_3000 + (32'($urandom_range(0, 15)) << 4)
                    + 32'($urandom_range(0, 15)));
    end

    $display("[TB] reset during a stalled request");
    cache_miss = 1'b1;
    address    = 32'h0000_7000;
    stepCycle();
    cache_miss = 1'b0;
    idx = modelFind(28'h0000700);
    checkOutput("abortLookupMiss", pf_miss, idx < 0);
    stepCycle();
    checkOutput("abortReqValid", mem_req_valid, 1);
    checkOutput("abortReqAddr", mem_req_addr, 32'h0000_7010);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin
        cache_miss = 1'b1;
        address    = 32'h0000_9000;
        fill_valid = 1'b1;
        fill_data  = randLine();
      end
      stepCycle();
      cache_miss = 1'b0;
      fill_valid = 1'b0;
      checkOutput("stallAddr", mem_req_addr, 32'h0000_7010);
      checkOutput("stallValid", mem_req_valid, 1);
    end
    rst = 1'b1;
    stepCycle();
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortValid", mem_req_valid, 0);
    checkOutput("abortAddr", mem_req_addr, 0);
    checkOutput("abortPfData", pf_data, 0);
    rst        = 1'b0;
    fill_valid = 1'b1;
    fill_data  = randLine();
    stepCycle();
    fill_valid = 1'b0;
    checkOutput("lateFillBusy", busy, 0);
    modelReset();
    applyStimulus(32'h0000_7000);
    applyStimulus(32'h0000_3004);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_prefetch_buffer.md
STREAM_PREFETCH_BUFFER -- requirements
Module: stream_prefetch_buffer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE_BYTE, default 16, meaning bytes per cache line (power of 2, >=4).
REQ-002 SHALL have parameter BUF_DEPTH, default 8, meaning prefetch-buffer entries (power of 2, 2..32).
REQ-003 SHALL have parameter DEGREE, default 2, meaning consecutive lines prefetched per demand miss (1..BUF_DEPTH).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-006 SHALL have ports as follows:
- cache_miss, input, 1: demand-miss strobe.
- address, input, 32: demand byte address.
- pf_hit, output, 1: one-cycle buffer-hit pulse.
- pf_miss, output, 1: one-cycle buffer-miss pulse.
- pf_data, output, BLOCK_SIZE_BYTE*8: hit line data.
- busy, output, 1: high when not IDLE.
- mem_req_valid, output, 1: prefetch request.
- mem_req_addr, output, 32: line-aligned request address.
- mem_req_ready, input, 1: memory accepts request.
- fill_valid, input, 1: fill data present.
- fill_data, input, BLOCK_SIZE_BYTE*8: fill line.

Function
REQ-007 SHALL hold per entry a valid bit, a line tag of address[31:log2(BLOCK_SIZE_BYTE)], and a data line.
REQ-008 SHALL implement FSM with states IDLE, LOOKUP, ISSUE, WAIT_FILL, and busy = (state != IDLE).
REQ-009 In IDLE, cache_miss=1 SHALL latch the line address of address and go to LOOKUP; cache_miss SHALL be ignored in every other state.
REQ-010 In LOOKUP, one cycle after the miss is accepted, SHALL assert exactly one of pf_hit/pf_miss for one cycle; on hit, pf_data = matching entry data, else pf_data holds its previous value.
REQ-011 Multiple matching entries SHALL be impossible (guaranteed by REQ-013); on a hit, the lowest-index valid match SHALL be selected.
REQ-012 LOOKUP SHALL go to ISSUE with candidate = latched line + 1 and issued count = 0.
REQ-013 In ISSUE, if the candidate line is already valid in the buffer, it SHALL be skipped in one cycle without a request; otherwise mem_req_valid=1 and mem_req_addr = candidate line shifted left by log2(BLOCK_SIZE_BYTE), held stable until mem_req_ready.
REQ-014 On mem_req_valid & mem_req_ready, the FSM SHALL go to WAIT_FILL and mem_req_valid SHALL drop the next cycle.
REQ-015 In WAIT_FILL, fill_valid=1 SHALL write {1, candidate, fill_data} to the entry at the round-robin pointer, overwriting any valid entry, and the pointer SHALL increment modulo BUF_DEPTH.
REQ-016 fill_valid outside WAIT_FILL SHALL be ignored.
REQ-017 After each skip or fill, count SHALL increment and candidate SHALL increment. When count reaches DEGREE, the FSM SHALL return to IDLE; otherwise it SHALL return to ISSUE.
REQ-018 Line-address arithmetic SHALL wrap modulo 2^(32-log2(BLOCK_SIZE_BYTE)); line 0 follows the all-ones line.
REQ-019 A lookup and a fill of the same line SHALL never coincide, because lookup occurs only in LOOKUP.

Reset
REQ-020 While rst=1 at a rising clock edge, the block SHALL clear all valid bits, the pointer and the count; enter IDLE; and drive pf_hit=0, pf_miss=0, mem_req_valid=0, busy=0, pf_data=0, mem_req_addr=0.
REQ-021 Reset asserted mid-request SHALL abandon the request; a later fill_valid SHALL be ignored.

Configuration
REQ-022 With macro PF_INVALIDATE_ON_HIT_EN defined, a LOOKUP hit SHALL clear the hit entry's valid bit in the same cycle as pf_hit, because the line moves to the cache. Without the macro, hit entries SHALL stay valid.

Verification
REQ-023 Scenario: reset, then miss at 0x0000_1000 (defaults). Required response: pf_miss pulse at LOOKUP; requests to 0x1010 then 0x1020, each held until ready; fills land in entries 0 and 1; busy is low after the second fill.
REQ-024 Scenario: after REQ-023, miss at 0x0000_1014. Required response: pf_hit, with pf_data equal to the 0x1010 fill. The only request is to 0x1030, because 0x1020 is skipped. Without the macro, a repeat miss at 0x1014 hits again; with it, the repeat miss gives pf_miss.
REQ-025 Scenario: miss at 0xFFFF_FFF0. Required response: requests to 0x0000_0000 and 0x0000_0010 (wrap).
REQ-026 Scenario: 5 misses at non-overlapping lines, 2 fills each (10 fills, BUF_DEPTH=8). Required response: the first 2 lines are evicted, and a miss to one of them gives pf_miss.
REQ-027 Scenario: hold mem_req_ready low for 7 cycles, pulse cache_miss and fill_valid during ISSUE, then assert rst. Required response: mem_req_addr is stable; the stray miss and fill have no effect; after reset all entries are invalid and the next miss gives pf_miss.
